// File: rtl/or8_serial_tx.sv
// or8_serial_tx: computes Y = A | B in two nibble steps, then streams Y out one bit
// per accepted valid/ready handshake and pulses done after the last bit.
module or8_serial_tx #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       busy,
    output logic [7:0] Y,
    output logic       sdata,
    output logic       svalid,
    input  logic       sready,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StCalcLo,
        StCalcHi,
        StShift,
        StDone
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_a;
    logic [7:0] w_a_next;
    logic [7:0] r_b;
    logic [7:0] w_b_next;
    logic [7:0] r_y;
    logic [7:0] w_y_next;
    logic [2:0] r_idx;
    logic [2:0] w_idx_next;
    logic [2:0] w_sel;

    // Bit of Y offered on the serial line for the current index.
    assign w_sel = (LSB_FIRST != 0) ? r_idx : (3'd7 - r_idx);
    assign Y     = r_y;

    // State and datapath registers; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_y     <= 8'h00;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_y     <= w_y_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_y_next     = r_y;
        w_idx_next   = r_idx;
        busy         = 1'b1;
        svalid       = 1'b0;
        sdata        = 1'b0;
        done         = 1'b0;

        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    w_a_next     = A;
                    w_b_next     = B;
                    w_idx_next   = 3'd0;
                    w_state_next = StCalcLo;
                end
            end
            StCalcLo: begin
                // Upper nibble is cleared here and filled on the next cycle.
                w_y_next     = {4'h0, r_a[3:0] | r_b[3:0]};
                w_state_next = StCalcHi;
            end
            StCalcHi: begin
                w_y_next[7:4] = r_a[7:4] | r_b[7:4];
                w_state_next  = StShift;
            end
            StShift: begin
                svalid = 1'b1;
                sdata  = r_y[w_sel];
                if (sready) begin
                    if (r_idx == 3'd7) begin
                        w_idx_next   = 3'd0;
                        w_state_next = StDone;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_or8_serial_tx.sv
// Self-checking bench for or8_serial_tx: two instances (LSB-first and MSB-first) share
// stimulus; a transaction-level model derives Y = A|B, the bit stream and done timing.
module tb_or8_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sready;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic       busy_l, svalid_l, sdata_l, done_l;
    logic [7:0] y_l;
    logic       busy_m, svalid_m, sdata_m, done_m;
    logic [7:0] y_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    or8_serial_tx #(.LSB_FIRST(1)) u_lsb (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy_l),
        .Y     (y_l),
        .sdata (sdata_l),
        .svalid(svalid_l),
        .sready(sready),
        .done  (done_l)
    );

    or8_serial_tx #(.LSB_FIRST(0)) u_msb (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy_m),
        .Y     (y_m),
        .sdata (sdata_m),
        .svalid(svalid_m),
        .sready(sready),
        .done  (done_m)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Both instances idle with the given held result.
    task automatic check_idle(input string tag, input logic [7:0] y_exp, input bit chk_sdata);
        check({tag, "_busy_l"}, {7'd0, busy_l}, 8'd0);
        check({tag, "_busy_m"}, {7'd0, busy_m}, 8'd0);
        check({tag, "_svalid_l"}, {7'd0, svalid_l}, 8'd0);
        check({tag, "_svalid_m"}, {7'd0, svalid_m}, 8'd0);
        check({tag, "_done_l"}, {7'd0, done_l}, 8'd0);
        check({tag, "_done_m"}, {7'd0, done_m}, 8'd0);
        check({tag, "_y_l"}, y_l, y_exp);
        check({tag, "_y_m"}, y_m, y_exp);
        if (chk_sdata) begin
            check({tag, "_sdata_l"}, {7'd0, sdata_l}, 8'd0);
            check({tag, "_sdata_m"}, {7'd0, sdata_m}, 8'd0);
        end
    endtask

    // One transaction. Called at a negedge while the DUTs are idle; returns at a negedge
    // in the IDLE cycle that follows DONE (or after a mid-transfer reset).
    // mode: 0 sready always 1, 1 four-cycle stall at bit 2, 2 random sready, 3 reset at bit 5.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int mode,
                         input bit hold_start, input bit chaos);
        logic [7:0] y;
        int         k;
        int         cyc;
        int         stalls;
        bit         rdy;
        y = a | b;

        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        cyc = 1;
        if (!hold_start) start = 1'b0;
        if (chaos) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
        end
        check("c1_busy_l", {7'd0, busy_l}, 8'd1);
        check("c1_svalid_m", {7'd0, svalid_m}, 8'd0);

        @(negedge clk);
        cyc = 2;
        check("c2_ylo_l", y_l, {4'h0, y[3:0]});
        check("c2_ylo_m", y_m, {4'h0, y[3:0]});
        check("c2_svalid_l", {7'd0, svalid_l}, 8'd0);

        @(negedge clk);
        cyc    = 3;
        k      = 0;
        stalls = 0;
        while (k < 8 && cyc < 200) begin
            check("sh_svalid_l", {7'd0, svalid_l}, 8'd1);
            check("sh_svalid_m", {7'd0, svalid_m}, 8'd1);
            check("sh_sdata_l", {7'd0, sdata_l}, {7'd0, y[k]});
            check("sh_sdata_m", {7'd0, sdata_m}, {7'd0, y[7-k]});
            check("sh_y_l", y_l, y);
            check("sh_y_m", y_m, y);
            check("sh_done_l", {7'd0, done_l}, 8'd0);
            if (mode == 3 && k == 5) begin
                // Reset with start also high: reset must win and leave no done pulse.
                rst    = 1'b1;
                start  = 1'b1;
                sready = 1'b1;
                @(negedge clk);
                check_idle("rst_mid", 8'h00, 1'b1);
                rst   = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check_idle("rst_after", 8'h00, 1'b1);
                return;
            end
            case (mode)
                1:       rdy = !(k == 2 && stalls < 4);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (!rdy) stalls++;
            if (chaos) begin
                start = 1'($urandom);
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
            end
            sready = rdy;
            if (rdy) k++;
            @(negedge clk);
            cyc++;
        end
        check("xfer_complete", 8'(k), 8'd8);

        check("dn_done_l", {7'd0, done_l}, 8'd1);
        check("dn_done_m", {7'd0, done_m}, 8'd1);
        check("dn_svalid_l", {7'd0, svalid_l}, 8'd0);
        check("dn_busy_m", {7'd0, busy_m}, 8'd1);
        check("dn_cycle", 8'(cyc), 8'(11 + stalls));
        check("dn_y_l", y_l, y);
        sready = 1'($urandom);
        if (chaos) start = 1'($urandom);

        @(negedge clk);
        check_idle("post", y, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sready = 1'b0;
        a_in   = 8'h00;
        b_in   = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset", 8'h00, 1'b1);

        // Reset has priority over start.
        start = 1'b1;
        a_in  = 8'hFF;
        @(negedge clk);
        check_idle("rst_prio", 8'h00, 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("rst_rel", 8'h00, 1'b1);

        do_op(8'hA5, 8'h0F, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 0, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 0, 1'b0, 1'b0);
        do_op(8'h3C, 8'h42, 1, 1'b0, 1'b0);
        do_op(8'h12, 8'h48, 0, 1'b0, 1'b1);
        do_op(8'h5A, 8'hC3, 3, 1'b0, 1'b0);
        do_op(8'h9E, 8'h21, 0, 1'b0, 1'b0);
        // Start held high across DONE: next op launches from the first IDLE cycle.
        do_op(8'h06, 8'h60, 0, 1'b1, 1'b0);
        do_op(8'hB0, 8'h0B, 2, 1'b1, 1'b0);
        do_op(8'h11, 8'h22, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 2, 1'b0, 1'($urandom));
        end
        start = 1'b0;
        @(negedge clk);
        check("final_busy_l", {7'd0, busy_l}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or8_serial_tx.md
OR8_SERIAL_TX -- requirements
Module: or8_serial_tx

Interface
REQ-001 Parameter: LSB_FIRST, default 1, serial bit order (1 = Y[0] first, 0 = Y[7] first).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 start  in  1  request pulse; A/B captured when accepted.
REQ-005 A  in  8  operand A.
REQ-006 B  in  8  operand B.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 Y  out  8  registered result A|B of the last accepted operation; held until next accept.
REQ-009 sdata  out  1  serial data bit; valid only while svalid=1.
REQ-010 svalid  out  1  serial bit offered to receiver.
REQ-011 sready  in  1  receiver accepts the current bit when svalid=1 and sready=1 in the same cycle.
REQ-012 done  out  1  one-cycle pulse after the last bit is accepted.

Function
REQ-013 FSM states: IDLE, CALC_LO, CALC_HI, SHIFT, DONE; encoding is implementation choice.
REQ-014 IDLE: start=1 registers A_r<=A and B_r<=B, clears the bit index to 0 -> CALC_LO; start=0 stays in IDLE.
REQ-015 start SHALL be ignored in every state other than IDLE; A/B changes outside IDLE have no effect.
REQ-016 CALC_LO: Y[3:0] <= A_r[3:0] | B_r[3:0]; Y[7:4] cleared to 0 -> CALC_HI unconditionally.
REQ-017 CALC_HI: Y[7:4] <= A_r[7:4] | B_r[7:4] -> SHIFT unconditionally.
REQ-018 SHIFT: svalid=1; sdata = Y[idx] when LSB_FIRST=1, else Y[7-idx]; idx is 3-bit.
REQ-019 SHIFT with sready=0: state, idx and sdata hold (bit held stable until accepted).
REQ-020 SHIFT with sready=1 and idx<7: idx increments; with idx=7: -> DONE, idx wraps to 0.
REQ-021 DONE: done=1, svalid=0 for exactly one cycle -> IDLE; start in DONE is ignored.
REQ-022 svalid SHALL be 0 in all states except SHIFT; done SHALL be 0 in all states except DONE.
REQ-023 Latency: start accepted at edge 0 -> svalid first high in cycle 3; with sready held 1, bits in cycles 3..10, done in cycle 11, IDLE (start accepted) in cycle 12.
REQ-024 Back-to-back: start held high continuously SHALL launch a new operation in the first IDLE cycle after DONE.
REQ-025 Y SHALL update only in CALC_LO/CALC_HI; Y stays stable during SHIFT, DONE and IDLE.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-SHIFT; the partial transfer is abandoned and no done pulse is produced.
REQ-027 Post-reset values: Y=8'h00, A_r=B_r=0, idx=0, busy=0, svalid=0, sdata=0, done=0.
REQ-028 rst has priority over start when both are high in the same cycle.

Verification
REQ-029 A=8'hA5, B=8'h0F, start pulse, sready=1, LSB_FIRST=1 -> Y=8'hAF after CALC_HI; sdata sequence 1,1,1,1,0,1,0,1 in cycles 3..10; done in cycle 11.
REQ-030 LSB_FIRST=0, A=8'h80, B=8'h01 -> Y=8'h81; sdata sequence 1,0,0,0,0,0,0,1.
REQ-031 sready=0 for 4 cycles while idx=2 -> sdata and svalid held stable; transfer resumes at idx=2 with no bit lost or duplicated; done delayed by 4 cycles.
REQ-032 start pulse and new A/B applied during SHIFT -> ignored; Y and serial stream unchanged.
REQ-033 rst asserted during SHIFT at idx=5 -> next cycle IDLE, svalid=0, Y=8'h00, no done pulse; a following start runs a full clean transfer.
REQ-034 A=8'h00, B=8'h00 and A=8'hFF, B=8'h00 -> Y=8'h00 (all-zero stream) and Y=8'hFF (all-one stream); exhaustive random A/B sweep against A|B reference model.
